// File: rtl/branch_pred_ctrl.sv
// Branch prediction sequencer: 2-bit saturating PHT, in-order queue of
// outstanding predictions, verdict generation, PHT training, flush on
// mispredict, and saturating hit/miss statistics.
module branch_pred_ctrl #(
    parameter int IDX_W = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_br_valid,
    input  logic [IDX_W-1:0] i_br_idx,
    output logic             o_stall,
    output logic             o_pred_valid,
    output logic             o_pred,
    input  logic             i_res_valid,
    input  logic             i_res_taken,
    output logic             o_res_valid,
    output logic             o_correct,
    output logic             o_flush,
    output logic [CNT_W-1:0] o_hit_cnt,
    output logic [CNT_W-1:0] o_miss_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned PHT_N = 1 << IDX_W;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [1:0]       pht_q    [PHT_N];
    logic [1:0]       pht_d    [PHT_N];
    logic [IDX_W-1:0] q_idx_q  [DEPTH];
    logic [IDX_W-1:0] q_idx_d  [DEPTH];
    logic             q_pred_q [DEPTH];
    logic             q_pred_d [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic [0:0]       state_q, state_d;
    logic             pred_valid_q, pred_valid_d;
    logic             pred_q, pred_d;
    logic             res_valid_q, res_valid_d;
    logic             correct_q, correct_d;
    logic             flush_q, flush_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic             stall;
    logic             push;
    logic             pop;
    logic             mispred;
    logic [IDX_W-1:0] head_idx;
    logic             head_pred;

    // Next-state: handshakes, queue bookkeeping, PHT training, verdicts, stats
    always_comb begin
        stall     = (occ_q == FULL_CNT) || (state_q == ST_FLUSH);
        push      = i_br_valid && !stall;
        pop       = i_res_valid && (occ_q != '0);
        head_idx  = q_idx_q[rd_ptr_q];
        head_pred = q_pred_q[rd_ptr_q];
        mispred   = pop && (head_pred != i_res_taken);

        pht_d      = pht_q;
        q_idx_d    = q_idx_q;
        q_pred_d   = q_pred_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        occ_d      = occ_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;

        // Prediction reads pht_q, so a same-cycle update never affects it.
        pred_valid_d = push && !mispred;
        pred_d       = push ? pht_q[i_br_idx][1] : 1'b0;
        res_valid_d  = pop;
        correct_d    = pop ? !mispred : 1'b1;
        flush_d      = mispred;
        state_d      = mispred ? ST_FLUSH : ST_RUN;

        if (pop) begin
            if (i_res_taken) begin
                if (pht_q[head_idx] != 2'b11) pht_d[head_idx] = pht_q[head_idx] + 2'b01;
            end else begin
                if (pht_q[head_idx] != 2'b00) pht_d[head_idx] = pht_q[head_idx] - 2'b01;
            end
            if (mispred) begin
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end else begin
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
            end
        end

        if (mispred) begin
            // Mispredict discards every younger entry and any same-cycle push.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                q_idx_d[wr_ptr_q]  = i_br_idx;
                q_pred_d[wr_ptr_q] = pht_q[i_br_idx][1];
                wr_ptr_d           = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      occ_d = occ_q + (PTR_W+1)'(1);
            else if (pop && !push) occ_d = occ_q - (PTR_W+1)'(1);
        end
    end

    // Control state, PHT and outputs with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pht_q        <= '{default: 2'b01};
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            occ_q        <= '0;
            state_q      <= ST_RUN;
            pred_valid_q <= 1'b0;
            pred_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            correct_q    <= 1'b1;
            flush_q      <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            pht_q        <= pht_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            occ_q        <= occ_d;
            state_q      <= state_d;
            pred_valid_q <= pred_valid_d;
            pred_q       <= pred_d;
            res_valid_q  <= res_valid_d;
            correct_q    <= correct_d;
            flush_q      <= flush_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Queue payload storage; validity is tracked by the pointers and occupancy
    always_ff @(posedge i_clk) begin
        q_idx_q  <= q_idx_d;
        q_pred_q <= q_pred_d;
    end

    assign o_stall      = stall;
    assign o_pred_valid = pred_valid_q;
    assign o_pred       = pred_q;
    assign o_res_valid  = res_valid_q;
    assign o_correct    = correct_q;
    assign o_flush      = flush_q;
    assign o_hit_cnt    = hit_cnt_q;
    assign o_miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed bench for branch_pred_ctrl with a reference model and a
// scoreboard of expected next-cycle outputs.
module tb_branch_pred_ctrl;

    typedef struct packed {
        logic [3:0] idx;
        logic       pred;
    } ent_t;

    typedef struct {
        logic        pv;
        logic        p;
        logic        rv;
        logic        c;
        logic        f;
        logic [15:0] h;
        logic [15:0] m;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br_valid;
    logic [3:0]  br_idx;
    logic        stall;
    logic        pred_valid;
    logic        pred;
    logic        res_valid;
    logic        res_taken;
    logic        res_out_valid;
    logic        correct;
    logic        flush;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int checks = 0;
    int errors = 0;

    logic [1:0]  m_pht [16];
    ent_t        m_q [$];
    logic        m_flush;
    logic [15:0] m_hit;
    logic [15:0] m_miss;
    exp_t        sb [$];

    branch_pred_ctrl #(
        .IDX_W(4),
        .DEPTH(4),
        .CNT_W(16)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_br_valid   (br_valid),
        .i_br_idx     (br_idx),
        .o_stall      (stall),
        .o_pred_valid (pred_valid),
        .o_pred       (pred),
        .i_res_valid  (res_valid),
        .i_res_taken  (res_taken),
        .o_res_valid  (res_out_valid),
        .o_correct    (correct),
        .o_flush      (flush),
        .o_hit_cnt    (hit_cnt),
        .o_miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pht[i] = 2'b01;
        m_q.delete();
        sb.delete();
        m_flush = 1'b0;
        m_hit   = '0;
        m_miss  = '0;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic bv, input logic [3:0] bi, input logic rv, input logic rt);
        logic m_stall, m_push, m_pop, m_corr, m_pre;
        ent_t h;
        ent_t n;
        exp_t e;
        br_valid  = bv;
        br_idx    = bi;
        res_valid = rv;
        res_taken = rt;
        #1;
        m_stall = (m_q.size() == 4) || m_flush;
        chk("stall", {31'd0, stall}, {31'd0, m_stall});
        m_push = bv && !m_stall;
        m_pop  = rv && (m_q.size() != 0);
        m_pre  = m_pht[bi][1];
        m_corr = 1'b1;
        if (m_pop) begin
            h = m_q.pop_front();
            m_corr = (h.pred == rt);
            if (rt && m_pht[h.idx] != 2'b11) m_pht[h.idx] = m_pht[h.idx] + 2'b01;
            if (!rt && m_pht[h.idx] != 2'b00) m_pht[h.idx] = m_pht[h.idx] - 2'b01;
            if (m_corr) begin
                if (m_hit != 16'hFFFF) m_hit = m_hit + 16'd1;
            end else begin
                if (m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
            end
        end
        if (m_pop && !m_corr) begin
            m_q.delete();
        end else if (m_push) begin
            n.idx  = bi;
            n.pred = m_pre;
            m_q.push_back(n);
        end
        m_flush = m_pop && !m_corr;
        e.pv = m_push && !(m_pop && !m_corr);
        e.p  = m_pre;
        e.rv = m_pop;
        e.c  = m_pop ? m_corr : 1'b1;
        e.f  = m_pop && !m_corr;
        e.h  = m_hit;
        e.m  = m_miss;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("pred_valid", {31'd0, pred_valid}, {31'd0, e.pv});
        if (e.pv) chk("pred", {31'd0, pred}, {31'd0, e.p});
        chk("res_valid", {31'd0, res_out_valid}, {31'd0, e.rv});
        chk("correct", {31'd0, correct}, {31'd0, e.c});
        chk("flush", {31'd0, flush}, {31'd0, e.f});
        chk("hit_cnt", {16'd0, hit_cnt}, {16'd0, e.h});
        chk("miss_cnt", {16'd0, miss_cnt}, {16'd0, e.m});
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        br_valid  = 1'b0;
        br_idx    = '0;
        res_valid = 1'b0;
        res_taken = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
        chk("rst_pred", {31'd0, pred}, 32'd0);
        chk("rst_res_valid", {31'd0, res_out_valid}, 32'd0);
        chk("rst_correct", {31'd0, correct}, 32'd1);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_hit", {16'd0, hit_cnt}, 32'd0);
        chk("rst_miss", {16'd0, miss_cnt}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // 1: weakly not-taken, taken outcome mispredicts and trains idx 3 up
        step(1'b1, 4'd3, 1'b0, 1'b0);
        chk("t1_pred_idx3", {31'd0, pred}, 32'd0);
        step(1'b0, 4'd0, 1'b1, 1'b1);
        chk("t1_flush", {31'd0, flush}, 32'd1);
        chk("t1_miss", {16'd0, miss_cnt}, 32'd1);
        step(1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b1, 4'd3, 1'b0, 1'b0);
        chk("t1_pred_idx3_after", {31'd0, pred}, 32'd1);
        step(1'b0, 4'd0, 1'b1, 1'b1);

        // 2: idx 5 saturates at 11, one not-taken brings it to 10
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 4'd5, 1'b0, 1'b0);
            step(1'b0, 4'd0, 1'b1, 1'b1);
            step(1'b0, 4'd0, 1'b0, 1'b0);
        end
        step(1'b1, 4'd5, 1'b0, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b1, 4'd5, 1'b0, 1'b0);
        chk("t2_pred_idx5", {31'd0, pred}, 32'd1);
        step(1'b0, 4'd0, 1'b1, 1'b1);

        // 3: fill the queue, drop a request while full, free one slot
        for (int k = 0; k < 4; k++) step(1'b1, 4'(k), 1'b0, 1'b0);
        chk("t3_full_stall", {31'd0, stall}, 32'd1);
        step(1'b1, 4'd4, 1'b0, 1'b0);
        chk("t3_dropped", {31'd0, pred_valid}, 32'd0);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk("t3_stall_released", {31'd0, stall}, 32'd0);

        // 4: three outstanding, oldest mispredicts with a push in the same cycle
        step(1'b1, 4'd6, 1'b1, 1'b1);
        chk("t4_flush", {31'd0, flush}, 32'd1);
        chk("t4_flush_stall", {31'd0, stall}, 32'd1);
        step(1'b1, 4'd6, 1'b1, 1'b1);
        chk("t4_ignored_res", {31'd0, res_out_valid}, 32'd0);
        step(1'b0, 4'd0, 1'b1, 1'b0);

        // 5: same-cycle push and pop on idx 7
        step(1'b1, 4'd7, 1'b0, 1'b0);
        step(1'b1, 4'd7, 1'b1, 1'b0);
        chk("t5_pred_idx7", {31'd0, pred}, 32'd0);
        step(1'b0, 4'd0, 1'b1, 1'b1);
        step(1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b1, 4'd7, 1'b1, 1'b1);
        step(1'b0, 4'd0, 1'b1, 1'b0);

        // 6: reset with outstanding entries and nonzero statistics
        step(1'b1, 4'd2, 1'b0, 1'b0);
        step(1'b1, 4'd5, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 4'd5, 1'b0, 1'b0);
        chk("t6_pred_idx5_reinit", {31'd0, pred}, 32'd0);
        step(1'b1, 4'd3, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
